pc_bcd_converter: RTL and testbench

// - Sequential double-dabble binary-to-BCD converter feeding the 7-seg PC display stage.
// - Captures the CPU PC and produces NUM_DIGITS decimal digits plus a leading-zero blank mask.
// - The display mux consumes these in place of raw hex nibbles.
// - A hex-bypass mode passes nibbles straight through.

---
 rtl/pc_bcd_converter_pkg.sv | 32 +++
 rtl/pc_bcd_converter_if.sv | 36 +++
 rtl/pc_bcd_converter_bcd_add3.sv | 17 +
 rtl/pc_bcd_converter.sv | 123 ++++++++++++
 tb/tb_pc_bcd_converter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_bcd_converter_pkg.sv
// Shared types and helpers for the PC display path.
// Double-dabble state, adjust constants and leading-zero mask.
package pc_display_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
  localparam int         MAX_DIGITS     = 8;

  // Digit i is blank when it and every digit above it are zero
  function automatic logic [MAX_DIGITS-1:0] calc_blank(
    input logic [4*MAX_DIGITS-1:0] d,
    input int                      n
  );
    logic                  nz;
    logic [MAX_DIGITS-1:0] b;
    nz = 1'b0;
    b  = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (i < n) begin
        nz   = nz | (d[4*i+:4] != 4'd0);
        b[i] = (i != 0) && !nz;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/pc_bcd_converter_if.sv
// Request/result bundle between the PC source and the BCD converter.
// master drives the request side, slave produces digits.
interface pc_bcd_converter_if #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 5
);

  logic [IN_WIDTH-1:0]     value_in;
  logic                    start;
  logic                    hex_mode;
  logic                    busy;
  logic                    done;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blank;

  modport master (
    output value_in,
    output start,
    output hex_mode,
    input  busy,
    input  done,
    input  digits,
    input  blank
  );

  modport slave (
    input  value_in,
    input  start,
    input  hex_mode,
    output busy,
    output done,
    output digits,
    output blank
  );

endinterface

// File: rtl/pc_bcd_converter_bcd_add3.sv
// One double-dabble digit adjust.
// Adds 3 to a BCD digit of 5 or more before the shift.
module bcd_add3
  import pc_display_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= BCD_ADJ_THRESH) begin
      d_o = d_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/pc_bcd_converter.sv
// Sequential binary-to-BCD converter for the PC display.
// One shift per clock; hex mode bypasses in a single edge.
module pc_bcd_converter
  import pc_display_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 5,
  parameter bit AUTO_START = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  pc_bcd_converter_if.slave bus
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH);
  localparam int SW = BW + IN_WIDTH;

  conv_state_t state_q, state_d;

  logic [IN_WIDTH-1:0]   shreg_q, shreg_d;
  logic [IN_WIDTH-1:0]   last_q, last_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [BW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic [BW-1:0]           bcd_adj;
  logic [BW-1:0]           hex_dig;
  logic [SW-1:0]           shifted;
  logic [4*MAX_DIGITS-1:0] dig_ext;
  logic                    go;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_adj (
      .d_i(bcd_q[4*g+:4]),
      .d_o(bcd_adj[4*g+:4])
    );
  end

  assign shifted = {bcd_adj, shreg_q} << 1;

  assign go = bus.start
            | (AUTO_START && (bus.value_in != last_q));

  always_comb begin
    hex_dig                = '0;
    hex_dig[IN_WIDTH-1:0]  = bus.value_in;
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          last_d = bus.value_in;
          if (bus.hex_mode) begin
            digits_d = hex_dig;
            done_d   = 1'b1;
          end else begin
            shreg_d = bus.value_in;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        bcd_d   = shifted[SW-1:IN_WIDTH];
        shreg_d = shifted[IN_WIDTH-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_WIDTH - 1)) begin
          digits_d = bcd_d;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mask is a pure function of the digits, so it tracks them exactly
  always_comb begin
    dig_ext         = '0;
    dig_ext[BW-1:0] = digits_d;
    blank_d         = NUM_DIGITS'(calc_blank(dig_ext, NUM_DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      last_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      blank_q  <= ~NUM_DIGITS'(1);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == CONVERT);
  assign bus.done   = done_q;
  assign bus.digits = digits_q;
  assign bus.blank  = blank_q;

endmodule

// File: tb/tb_pc_bcd_converter.sv
// Bench for pc_bcd_converter: manual (A) and auto-start (B) instances.
// Expected results queue on drive and are popped on done.
module tb_pc_bcd_converter;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int checks;
  int errors;

  pc_bcd_converter_if #(.IN_WIDTH(16), .NUM_DIGITS(5)) ifa ();
  pc_bcd_converter_if #(.IN_WIDTH(16), .NUM_DIGITS(5)) ifb ();

  pc_bcd_converter #(
    .IN_WIDTH(16), .NUM_DIGITS(5), .AUTO_START(1'b0)
  ) u_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ifa.slave)
  );

  pc_bcd_converter #(
    .IN_WIDTH(16), .NUM_DIGITS(5), .AUTO_START(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_b_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] v;
    bit          hex;
    logic [19:0] d;
    logic [4:0]  b;
  } vec_t;

  vec_t vec[12];

  logic [24:0] qa[$];
  logic [24:0] qb[$];

  function automatic logic [19:0] model_d(logic [15:0] v, bit hex);
    logic [19:0] r;
    int x;
    r = '0;
    x = int'(v);
    if (hex) begin
      r[15:0] = v;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r[4*i+:4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic [4:0] model_b(logic [19:0] d);
    logic [4:0] r;
    bit seen;
    r = '0;
    seen = 1'b0;
    for (int i = 4; i >= 1; i--) begin
      if (d[4*i+:4] != 4'd0) seen = 1'b1;
      r[i] = !seen;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.done === 1'b1) begin
      logic [24:0] e;
      if (qa.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_digits", 32'(ifa.digits), 32'(e[24:5]));
        chk("a_blank", 32'(ifa.blank), 32'(e[4:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.done === 1'b1) begin
      logic [24:0] e;
      if (qb.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_digits", 32'(ifb.digits), 32'(e[24:5]));
        chk("b_blank", 32'(ifb.blank), 32'(e[4:0]));
      end
    end
  end

  task automatic run_a(logic [15:0] v, bit hex,
                       logic [19:0] d, logic [4:0] b);
    int lat;
    @(negedge clk);
    ifa.value_in = v;
    ifa.hex_mode = hex;
    ifa.start    = 1'b1;
    qa.push_back({d, b});
    @(negedge clk);
    ifa.start = 1'b0;
    chk("a_busy_after_go", 32'(ifa.busy), hex ? 32'd0 : 32'd1);
    lat = 1;
    while (ifa.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("a_latency", 32'(lat), hex ? 32'd1 : 32'd17);
    @(negedge clk);
    chk("a_done_width", 32'(ifa.done), 32'd0);
  endtask

  task automatic drain(bit which);
    int n;
    n = 0;
    while ((which ? qb.size() : qa.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(which ? "b_drain" : "a_drain",
        32'(which ? qb.size() : qa.size()), 32'd0);
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rv;
    logic [19:0] rd;
    checks = 0;
    errors = 0;

    vec[0]  = '{16'hFFFF, 1'b0, 20'h65535, 5'b00000};
    vec[1]  = '{16'h0000, 1'b0, 20'h00000, 5'b11110};
    vec[2]  = '{16'h0A3F, 1'b1, 20'h00A3F, 5'b11000};
    vec[3]  = '{16'd1234, 1'b0, 20'h01234, 5'b10000};
    vec[4]  = '{16'd256,  1'b0, 20'h00256, 5'b11000};
    vec[5]  = '{16'd10000, 1'b0, 20'h10000, 5'b00000};
    vec[6]  = '{16'h0009, 1'b1, 20'h00009, 5'b11110};
    vec[7]  = '{16'hFFFF, 1'b1, 20'h0FFFF, 5'b10000};
    vec[8]  = '{16'd100,  1'b0, 20'h00100, 5'b11000};
    vec[9]  = '{16'd99,   1'b0, 20'h00099, 5'b11100};
    vec[10] = '{16'd9999, 1'b0, 20'h09999, 5'b10000};
    vec[11] = '{16'd5,    1'b0, 20'h00005, 5'b11110};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.value_in = '0;
    ifa.start    = 1'b0;
    ifa.hex_mode = 1'b0;
    ifb.value_in = '0;
    ifb.start    = 1'b0;
    ifb.hex_mode = 1'b0;
    idle(3);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_digits", 32'(ifa.digits), 32'd0);
    chk("rst_blank", 32'(ifa.blank), 32'h1E);
    chk("rst_b_blank", 32'(ifb.blank), 32'h1E);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_a(vec[i].v, vec[i].hex, vec[i].d, vec[i].b);
      drain(1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      rv = 16'($urandom_range(0, 65535));
      rd = model_d(rv, i[0]);
      run_a(rv, i[0], rd, model_b(rd));
      drain(1'b0);
    end

    // Busy ignore: re-request mid conversion must be dropped
    run_a(16'd7, 1'b0, 20'h00007, 5'b11110);
    @(negedge clk);
    ifa.value_in = 16'd1234;
    ifa.start    = 1'b1;
    qa.push_back({20'h01234, 5'b10000});
    @(negedge clk);
    ifa.start = 1'b0;
    idle(4);
    ifa.value_in = 16'd999;
    ifa.hex_mode = 1'b1;
    ifa.start    = 1'b1;
    @(negedge clk);
    ifa.start    = 1'b0;
    ifa.hex_mode = 1'b0;
    chk("a_busy_mid", 32'(ifa.busy), 32'd1);
    chk("a_digits_hold", 32'(ifa.digits), 32'h00007);
    drain(1'b0);
    idle(25);

    // Reset mid conversion
    @(negedge clk);
    ifa.value_in = 16'd4321;
    ifa.start    = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    idle(7);
    rst_a_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_done", 32'(ifa.done), 32'd0);
    chk("midrst_digits", 32'(ifa.digits), 32'd0);
    chk("midrst_blank", 32'(ifa.blank), 32'h1E);
    idle(2);
    rst_a_n = 1'b1;
    idle(25);
    run_a(16'd4321, 1'b0, 20'h04321, 5'b10000);
    drain(1'b0);

    // Auto-start instance
    idle(20);
    ifb.value_in = 16'h0100;
    qb.push_back({20'h00256, 5'b11000});
    drain(1'b1);
    idle(30);
    ifb.value_in = 16'd300;
    qb.push_back({20'h00300, 5'b11000});
    idle(5);
    chk("b_busy_mid", 32'(ifb.busy), 32'd1);
    ifb.value_in = 16'd4000;
    qb.push_back({20'h04000, 5'b10000});
    drain(1'b1);
    idle(30);
    chk("b_idle_after", 32'(ifb.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
